// File: rtl/cpu_alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the cpu_alu_seq ALU.
package cpu_alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADC  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_SBC  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_CP   = 5'b00111;
    localparam logic [4:0] OP_INC  = 5'b01000;
    localparam logic [4:0] OP_DEC  = 5'b01001;
    localparam logic [4:0] OP_CPL  = 5'b01010;
    localparam logic [4:0] OP_SWAP = 5'b01011;
    localparam logic [4:0] OP_RL   = 5'b01100;
    localparam logic [4:0] OP_RR   = 5'b01101;
    localparam logic [4:0] OP_RLC  = 5'b01110;
    localparam logic [4:0] OP_RRC  = 5'b01111;
    localparam logic [4:0] OP_SLA  = 5'b10000;
    localparam logic [4:0] OP_SRA  = 5'b10001;
    localparam logic [4:0] OP_SRL  = 5'b10010;
    localparam logic [4:0] OP_BIT  = 5'b10011;
    localparam logic [4:0] OP_SET  = 5'b10100;
    localparam logic [4:0] OP_RES  = 5'b10101;
    localparam logic [4:0] OP_DAA  = 5'b10110;
    localparam logic [4:0] OP_SCF  = 5'b10111;
    localparam logic [4:0] OP_CCF  = 5'b11000;

    localparam int F_Z = 7;
    localparam int F_N = 6;
    localparam int F_H = 5;
    localparam int F_C = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    // Rotates and shifts occupy one contiguous opcode range.
    function automatic logic is_iter(input logic [4:0] op);
        return (op >= OP_RL) && (op <= OP_SRL);
    endfunction

endpackage

// File: rtl/cpu_alu_addsub.sv
// Combinational DATA_W adder/subtractor with carry-in; C from the top bit,
// H from the carry/borrow out of bit DATA_W-5.
module cpu_alu_addsub #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  logic              sub,
    output logic [DATA_W-1:0] res,
    output logic              c,
    output logic              h
);

    logic [DATA_W:0]   full;
    logic [DATA_W-4:0] low;

    always_comb begin
        if (sub) begin
            full = {1'b0, a} - {1'b0, b} - (DATA_W+1)'(cin);
            low  = {1'b0, a[DATA_W-5:0]} - {1'b0, b[DATA_W-5:0]} - (DATA_W-3)'(cin);
        end else begin
            full = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(cin);
            low  = {1'b0, a[DATA_W-5:0]} + {1'b0, b[DATA_W-5:0]} + (DATA_W-3)'(cin);
        end
    end

    assign res = full[DATA_W-1:0];
    assign c   = full[DATA_W];
    assign h   = low[DATA_W-4];

endmodule

// File: rtl/cpu_alu_seq.sv
// Sequenced ALU owning flag register F; rotates/shifts iterate one bit per cycle.
// Build option: define CPU_ALU_DAA_EN to implement DAA (otherwise it is illegal).
//
// state   | meaning
// S_IDLE  | waiting for a request, op_ready high
// S_EXEC  | single-cycle operation, result registered on exit
// S_SHIFT | one rotate/shift step per cycle until the down-counter expires
module cpu_alu_seq
    import cpu_alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk4_2,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [4:0]        op_code,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [CNT_W-1:0]  op_cnt,
    input  logic              flag_wr,
    input  logic [7:0]        flag_data,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [7:0]        F
);

    localparam logic [CNT_W:0]    CNT_ONE = (CNT_W+1)'(1);
    localparam logic [DATA_W-1:0] ONE_D   = DATA_W'(1);

    state_t            state, state_nx;
    logic [CNT_W:0]    cnt;
    logic [4:0]        op_q;
    logic [DATA_W-1:0] val, b_q;
    logic [CNT_W-1:0]  idx;
    logic              c_run;

    logic [DATA_W-1:0] as_b, as_res, bit_mask, ex_res, st_val;
    logic              as_cin, as_sub, as_c, as_h, bit_val, ex_wf, st_c, last_step;
    logic [7:0]        ex_f;
`ifdef CPU_ALU_DAA_EN
    logic [7:0]        daa_lo;
    logic              daa_c;
`endif

    assign op_ready  = (state == S_IDLE);
    assign last_step = (cnt <= CNT_ONE);
    assign bit_mask  = ONE_D << idx;
    assign bit_val   = |(val & bit_mask);

    cpu_alu_addsub #(.DATA_W(DATA_W)) u_addsub (
        .a   (val),
        .b   (as_b),
        .cin (as_cin),
        .sub (as_sub),
        .res (as_res),
        .c   (as_c),
        .h   (as_h)
    );

    // c_run holds the carry captured at accept, so ADC/SBC ignore later flag_wr.
    always_comb begin
        as_b   = b_q;
        as_cin = 1'b0;
        as_sub = 1'b0;
        case (op_q)
            OP_ADC:        as_cin = c_run;
            OP_SUB, OP_CP: as_sub = 1'b1;
            OP_SBC: begin as_sub = 1'b1; as_cin = c_run; end
            OP_INC:        as_b = ONE_D;
            OP_DEC: begin as_b = ONE_D; as_sub = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        ex_res = val;
        ex_f   = F;
        ex_wf  = 1'b1;
`ifdef CPU_ALU_DAA_EN
        daa_lo = val[7:0];
        daa_c  = F[F_C];
`endif
        case (op_q)
            OP_ADD, OP_ADC: begin ex_res = as_res; ex_f = {as_res == '0, 1'b0, as_h, as_c, 4'h0}; end
            OP_SUB, OP_SBC: begin ex_res = as_res; ex_f = {as_res == '0, 1'b1, as_h, as_c, 4'h0}; end
            OP_CP:          ex_f = {as_res == '0, 1'b1, as_h, as_c, 4'h0};
            OP_AND: begin ex_res = val & b_q; ex_f = {(val & b_q) == '0, 3'b010, 4'h0}; end
            OP_XOR: begin ex_res = val ^ b_q; ex_f = {(val ^ b_q) == '0, 7'h00}; end
            OP_OR:  begin ex_res = val | b_q; ex_f = {(val | b_q) == '0, 7'h00}; end
            OP_INC: begin ex_res = as_res; ex_f = {as_res == '0, 1'b0, as_h, F[F_C], 4'h0}; end
            OP_DEC: begin ex_res = as_res; ex_f = {as_res == '0, 1'b1, as_h, F[F_C], 4'h0}; end
            OP_CPL: begin ex_res = ~val; ex_f = {F[F_Z], 2'b11, F[F_C], 4'h0}; end
            OP_SWAP: begin
                ex_res = {val[DATA_W/2-1:0], val[DATA_W-1:DATA_W/2]};
                ex_f   = {val == '0, 7'h00};
            end
            OP_BIT: ex_f = {~bit_val, 2'b01, F[F_C], 4'h0};
            OP_SET: begin ex_res = val | bit_mask;  ex_wf = 1'b0; end
            OP_RES: begin ex_res = val & ~bit_mask; ex_wf = 1'b0; end
`ifdef CPU_ALU_DAA_EN
            OP_DAA: begin
                if (!F[F_N]) begin
                    if (F[F_C] || (val[7:0] > 8'h99)) begin
                        daa_lo = daa_lo + 8'h60;
                        daa_c  = 1'b1;
                    end
                    if (F[F_H] || (val[3:0] > 4'h9)) daa_lo = daa_lo + 8'h06;
                end else begin
                    if (F[F_C]) daa_lo = daa_lo - 8'h60;
                    if (F[F_H]) daa_lo = daa_lo - 8'h06;
                end
                ex_res[7:0] = daa_lo;
                ex_f        = {daa_lo == 8'h00, F[F_N], 1'b0, daa_c, 4'h0};
            end
`endif
            OP_SCF: ex_f = {F[F_Z], 3'b001, 4'h0};
            OP_CCF: ex_f = {F[F_Z], 2'b00, ~F[F_C], 4'h0};
            default: ex_wf = 1'b0;
        endcase
    end

    always_comb begin
        st_val = val;
        st_c   = c_run;
        case (op_q)
            OP_RL:  begin st_val = {val[DATA_W-2:0], c_run};      st_c = val[DATA_W-1]; end
            OP_RR:  begin st_val = {c_run, val[DATA_W-1:1]};      st_c = val[0];        end
            OP_RLC: begin st_val = {val[DATA_W-2:0], val[DATA_W-1]}; st_c = val[DATA_W-1]; end
            OP_RRC: begin st_val = {val[0], val[DATA_W-1:1]};     st_c = val[0];        end
            OP_SLA: begin st_val = {val[DATA_W-2:0], 1'b0};       st_c = val[DATA_W-1]; end
            OP_SRA: begin st_val = {val[DATA_W-1], val[DATA_W-1:1]}; st_c = val[0];     end
            OP_SRL: begin st_val = {1'b0, val[DATA_W-1:1]};       st_c = val[0];        end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (op_valid) state_nx = is_iter(op_code) ? S_SHIFT : S_EXEC;
            S_EXEC:  state_nx = S_IDLE;
            S_SHIFT: if (last_step) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk4_2) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            val       <= '0;
            b_q       <= '0;
            idx       <= '0;
            c_run     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            F         <= 8'h00;
        end else begin
            state     <= state_nx;
            res_valid <= 1'b0;
            if (flag_wr) F <= flag_data & 8'hF0;
            // Completing ops write F after flag_wr so the op's flags win.
            case (state)
                S_IDLE: if (op_valid) begin
                    val   <= op_a;
                    b_q   <= op_b;
                    idx   <= op_cnt;
                    op_q  <= op_code;
                    c_run <= F[F_C];
                    cnt   <= (op_cnt == '0) ? CNT_ONE : {1'b0, op_cnt};
                end
                S_EXEC: begin
                    res_valid <= 1'b1;
                    res_data  <= ex_res;
                    if (ex_wf) F <= ex_f;
                end
                S_SHIFT: begin
                    val   <= st_val;
                    c_run <= st_c;
                    cnt   <= cnt - CNT_ONE;
                    if (last_step) begin
                        res_valid <= 1'b1;
                        res_data  <= st_val;
                        F         <= {st_val == '0, 2'b00, st_c, 4'h0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Directed self-checking bench for cpu_alu_seq at DATA_W=8 and DATA_W=16.
module tb_cpu_alu_seq;

    localparam logic [4:0] OPC_ADD = 5'h00, OPC_ADC = 5'h01, OPC_SUB = 5'h02, OPC_SBC = 5'h03;
    localparam logic [4:0] OPC_AND = 5'h04, OPC_XOR = 5'h05, OPC_OR = 5'h06, OPC_CP = 5'h07;
    localparam logic [4:0] OPC_INC = 5'h08, OPC_DEC = 5'h09, OPC_CPL = 5'h0A, OPC_SWAP = 5'h0B;
    localparam logic [4:0] OPC_RL = 5'h0C, OPC_RR = 5'h0D, OPC_RLC = 5'h0E, OPC_RRC = 5'h0F;
    localparam logic [4:0] OPC_SLA = 5'h10, OPC_SRA = 5'h11, OPC_SRL = 5'h12, OPC_BIT = 5'h13;
    localparam logic [4:0] OPC_SET = 5'h14, OPC_RES = 5'h15, OPC_DAA = 5'h16, OPC_SCF = 5'h17;
    localparam logic [4:0] OPC_CCF = 5'h18;

    logic clk = 1'b0;
    logic reset;

    logic        op_valid8, op_ready8, flag_wr8, res_valid8;
    logic [4:0]  op_code8;
    logic [7:0]  op_a8, op_b8, flag_data8, res_data8, F8;
    logic [2:0]  op_cnt8;

    logic        op_valid16, op_ready16, flag_wr16, res_valid16;
    logic [4:0]  op_code16;
    logic [15:0] op_a16, op_b16, res_data16;
    logic [7:0]  flag_data16, F16;
    logic [3:0]  op_cnt16;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] cnt;
        logic [7:0] fpre;
        logic [7:0] res;
        logic [7:0] f;
        logic [3:0] lat;
    } vec_t;

    always #5 clk = ~clk;

    cpu_alu_seq #(.DATA_W(8)) d8 (
        .clk4_2(clk), .reset(reset), .op_valid(op_valid8), .op_ready(op_ready8),
        .op_code(op_code8), .op_a(op_a8), .op_b(op_b8), .op_cnt(op_cnt8),
        .flag_wr(flag_wr8), .flag_data(flag_data8), .res_valid(res_valid8),
        .res_data(res_data8), .F(F8)
    );

    cpu_alu_seq #(.DATA_W(16)) d16 (
        .clk4_2(clk), .reset(reset), .op_valid(op_valid16), .op_ready(op_ready16),
        .op_code(op_code16), .op_a(op_a16), .op_b(op_b16), .op_cnt(op_cnt16),
        .flag_wr(flag_wr16), .flag_data(flag_data16), .res_valid(res_valid16),
        .res_data(res_data16), .F(F16)
    );

    task automatic setf8(input logic [7:0] v);
        @(negedge clk);
        flag_wr8 = 1'b1; flag_data8 = v;
        @(posedge clk); #1;
        flag_wr8 = 1'b0;
    endtask

    // lat counts in the cycle numbering where EXEC ops finish at accept+2.
    task automatic run8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] c, output logic [7:0] r, output logic [7:0] f,
                        output int lat, output int low);
        @(negedge clk);
        op_code8 = op; op_a8 = a; op_b8 = b; op_cnt8 = c; op_valid8 = 1'b1;
        @(posedge clk); #1;
        op_valid8 = 1'b0;
        lat = 1; low = 0;
        while (!res_valid8 && lat < 40) begin
            if (!op_ready8) low++;
            @(posedge clk); #1;
            lat++;
        end
        if (!res_valid8) lat = -1;
        r = res_data8; f = F8;
    endtask

    task automatic run16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] c, output logic [15:0] r, output logic [7:0] f,
                         output int lat);
        @(negedge clk);
        op_code16 = op; op_a16 = a; op_b16 = b; op_cnt16 = c; op_valid16 = 1'b1;
        @(posedge clk); #1;
        op_valid16 = 1'b0;
        lat = 1;
        while (!res_valid16 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!res_valid16) lat = -1;
        r = res_data16; f = F16;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (op_ready8 !== 1'b1) $display("FAIL reset_op_ready got %b exp 1", op_ready8); else passed++;
        total++; if (res_valid8 !== 1'b0) $display("FAIL reset_res_valid got %b exp 0", res_valid8); else passed++;
        total++; if (res_data8 !== 8'h00) $display("FAIL reset_res_data got %h exp 00", res_data8); else passed++;
        total++; if (F8 !== 8'h00) $display("FAIL reset_F got %h exp 00", F8); else passed++;
        total++; if (F16 !== 8'h00 || res_data16 !== 16'h0) $display("FAIL reset_d16 got F=%h res=%h exp 00/0000", F16, res_data16); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_exec_ops();
        vec_t v[$];
        logic [7:0] r, f;
        int lat, low;
        v.push_back(vec_t'{OPC_ADD,  8'h3A, 8'hC6, 3'd0, 8'h00, 8'h00, 8'hB0, 4'd2});
        v.push_back(vec_t'{OPC_SUB,  8'h3E, 8'h0F, 3'd0, 8'h00, 8'h2F, 8'h60, 4'd2});
        v.push_back(vec_t'{OPC_CP,   8'h3E, 8'h0F, 3'd0, 8'h00, 8'h3E, 8'h60, 4'd2});
        v.push_back(vec_t'{OPC_ADC,  8'h01, 8'h01, 3'd0, 8'h10, 8'h03, 8'h00, 4'd2});
        v.push_back(vec_t'{OPC_SBC,  8'h10, 8'h00, 3'd0, 8'h10, 8'h0F, 8'h60, 4'd2});
        v.push_back(vec_t'{OPC_AND,  8'hF0, 8'h3C, 3'd0, 8'h00, 8'h30, 8'h20, 4'd2});
        v.push_back(vec_t'{OPC_XOR,  8'hFF, 8'hFF, 3'd0, 8'h00, 8'h00, 8'h80, 4'd2});
        v.push_back(vec_t'{OPC_OR,   8'h12, 8'h40, 3'd0, 8'hF0, 8'h52, 8'h00, 4'd2});
        v.push_back(vec_t'{OPC_INC,  8'hFF, 8'h00, 3'd0, 8'h10, 8'h00, 8'hB0, 4'd2});
        v.push_back(vec_t'{OPC_DEC,  8'h10, 8'h00, 3'd0, 8'h10, 8'h0F, 8'h70, 4'd2});
        v.push_back(vec_t'{OPC_CPL,  8'h35, 8'h00, 3'd0, 8'h90, 8'hCA, 8'hF0, 4'd2});
        v.push_back(vec_t'{OPC_SWAP, 8'hA5, 8'h00, 3'd0, 8'hF0, 8'h5A, 8'h00, 4'd2});
        v.push_back(vec_t'{OPC_BIT,  8'h08, 8'h00, 3'd3, 8'h10, 8'h08, 8'h30, 4'd2});
        v.push_back(vec_t'{OPC_BIT,  8'h08, 8'h00, 3'd4, 8'h00, 8'h08, 8'hA0, 4'd2});
        v.push_back(vec_t'{OPC_SET,  8'h00, 8'h00, 3'd7, 8'h50, 8'h80, 8'h50, 4'd2});
        v.push_back(vec_t'{OPC_RES,  8'hFF, 8'h00, 3'd0, 8'h50, 8'hFE, 8'h50, 4'd2});
        v.push_back(vec_t'{OPC_SCF,  8'h33, 8'h00, 3'd0, 8'h80, 8'h33, 8'h90, 4'd2});
        v.push_back(vec_t'{OPC_CCF,  8'h33, 8'h00, 3'd0, 8'h90, 8'h33, 8'h80, 4'd2});
        v.push_back(vec_t'{OPC_CCF,  8'h33, 8'h00, 3'd0, 8'h60, 8'h33, 8'h10, 4'd2});
        v.push_back(vec_t'{5'h1F,    8'h5C, 8'h11, 3'd0, 8'h70, 8'h5C, 8'h70, 4'd2});
        v.push_back(vec_t'{5'h19,    8'h01, 8'h22, 3'd0, 8'h30, 8'h01, 8'h30, 4'd2});
        foreach (v[i]) begin
            setf8(v[i].fpre);
            run8(v[i].op, v[i].a, v[i].b, v[i].cnt, r, f, lat, low);
            total++; if (r !== v[i].res) $display("FAIL exec[%0d] res_data got %h exp %h", i, r, v[i].res); else passed++;
            total++; if (f !== v[i].f) $display("FAIL exec[%0d] F got %h exp %h", i, f, v[i].f); else passed++;
            total++; if (lat !== int'(v[i].lat)) $display("FAIL exec[%0d] latency got %0d exp %0d", i, lat, v[i].lat); else passed++;
        end
    endtask

    task automatic test_shift_ops();
        vec_t v[$];
        logic [7:0] r, f;
        int lat, low;
        v.push_back(vec_t'{OPC_RL,  8'h81, 8'h00, 3'd3, 8'h00, 8'h0A, 8'h00, 4'd4});
        v.push_back(vec_t'{OPC_SRA, 8'h81, 8'h00, 3'd1, 8'h00, 8'hC0, 8'h10, 4'd2});
        v.push_back(vec_t'{OPC_SRL, 8'h01, 8'h00, 3'd0, 8'h00, 8'h00, 8'h90, 4'd2});
        v.push_back(vec_t'{OPC_RR,  8'h00, 8'h00, 3'd1, 8'h10, 8'h80, 8'h00, 4'd2});
        v.push_back(vec_t'{OPC_RLC, 8'h80, 8'h00, 3'd2, 8'h00, 8'h02, 8'h00, 4'd3});
        v.push_back(vec_t'{OPC_RRC, 8'h01, 8'h00, 3'd7, 8'h00, 8'h02, 8'h00, 4'd8});
        v.push_back(vec_t'{OPC_SLA, 8'h40, 8'h00, 3'd2, 8'h00, 8'h00, 8'h90, 4'd3});
        v.push_back(vec_t'{OPC_RL,  8'h80, 8'h00, 3'd1, 8'h10, 8'h01, 8'h10, 4'd2});
        foreach (v[i]) begin
            setf8(v[i].fpre);
            run8(v[i].op, v[i].a, v[i].b, v[i].cnt, r, f, lat, low);
            total++; if (r !== v[i].res) $display("FAIL shift[%0d] res_data got %h exp %h", i, r, v[i].res); else passed++;
            total++; if (f !== v[i].f) $display("FAIL shift[%0d] F got %h exp %h", i, f, v[i].f); else passed++;
            total++; if (lat !== int'(v[i].lat)) $display("FAIL shift[%0d] latency got %0d exp %0d", i, lat, v[i].lat); else passed++;
            total++; if (low !== int'(v[i].lat) - 1) $display("FAIL shift[%0d] op_ready_low got %0d exp %0d", i, low, int'(v[i].lat) - 1); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r, f;
        int lat, low;
        setf8(8'h00);
        run8(OPC_ADD, 8'h01, 8'h02, 3'd0, r, f, lat, low);
        total++; if (r !== 8'h03) $display("FAIL b2b_first_res got %h exp 03", r); else passed++;
        total++; if (op_ready8 !== 1'b1) $display("FAIL b2b_ready_with_valid got %b exp 1", op_ready8); else passed++;
        op_code8 = OPC_SUB; op_a8 = 8'h05; op_b8 = 8'h05; op_cnt8 = 3'd0; op_valid8 = 1'b1;
        @(posedge clk); #1;
        op_valid8 = 1'b0;
        total++; if (op_ready8 !== 1'b0) $display("FAIL b2b_accepted got op_ready %b exp 0", op_ready8); else passed++;
        @(posedge clk); #1;
        total++; if (res_valid8 !== 1'b1 || res_data8 !== 8'h00) $display("FAIL b2b_second got valid=%b res=%h exp 1/00", res_valid8, res_data8); else passed++;
        total++; if (F8 !== 8'hC0) $display("FAIL b2b_second_F got %h exp C0", F8); else passed++;
        @(posedge clk); #1;
        total++; if (res_valid8 !== 1'b0) $display("FAIL b2b_pulse_width got %b exp 0", res_valid8); else passed++;
    endtask

    task automatic test_flag_wr();
        setf8(8'h00);
        @(negedge clk);
        op_code8 = OPC_ADD; op_a8 = 8'h3A; op_b8 = 8'hC6; op_cnt8 = 3'd0; op_valid8 = 1'b1;
        @(posedge clk); #1;
        op_valid8 = 1'b0; flag_wr8 = 1'b1; flag_data8 = 8'h4F;
        @(posedge clk); #1;
        flag_wr8 = 1'b0;
        total++; if (res_valid8 !== 1'b1 || F8 !== 8'hB0) $display("FAIL flag_wr_vs_op got valid=%b F=%h exp 1/B0", res_valid8, F8); else passed++;
        setf8(8'h10);
        @(negedge clk);
        op_code8 = OPC_RL; op_a8 = 8'h00; op_b8 = 8'h00; op_cnt8 = 3'd2; op_valid8 = 1'b1;
        @(posedge clk); #1;
        op_valid8 = 1'b0; flag_wr8 = 1'b1; flag_data8 = 8'h00;
        @(posedge clk); #1;
        flag_wr8 = 1'b0;
        total++; if (F8 !== 8'h00 || res_valid8 !== 1'b0) $display("FAIL flag_wr_midop got F=%h valid=%b exp 00/0", F8, res_valid8); else passed++;
        @(posedge clk); #1;
        total++; if (res_valid8 !== 1'b1 || res_data8 !== 8'h02) $display("FAIL captured_carry got valid=%b res=%h exp 1/02", res_valid8, res_data8); else passed++;
    endtask

    task automatic test_reset_midop();
        int pulses = 0;
        setf8(8'hA0);
        @(negedge clk);
        op_code8 = OPC_SRL; op_a8 = 8'h80; op_b8 = 8'h00; op_cnt8 = 3'd7; op_valid8 = 1'b1;
        @(posedge clk); #1;
        op_valid8 = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (res_valid8) pulses++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (op_ready8 !== 1'b1) $display("FAIL midreset_op_ready got %b exp 1", op_ready8); else passed++;
        total++; if (F8 !== 8'h00) $display("FAIL midreset_F got %h exp 00", F8); else passed++;
        total++; if (res_data8 !== 8'h00) $display("FAIL midreset_res_data got %h exp 00", res_data8); else passed++;
        repeat (10) begin
            @(posedge clk); #1;
            if (res_valid8) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL midreset_no_res_valid got %0d pulses exp 0", pulses); else passed++;
        setf8(8'hFF);
        total++; if (F8 !== 8'hF0) $display("FAIL flag_wr_idle got %h exp F0", F8); else passed++;
    endtask

    task automatic test_width16();
        logic [15:0] r;
        logic [7:0]  f;
        int lat;
        run16(OPC_ADD, 16'h0FFF, 16'h0001, 4'd0, r, f, lat);
        total++; if (r !== 16'h1000 || f !== 8'h20) $display("FAIL w16_add got %h/%h exp 1000/20", r, f); else passed++;
        total++; if (lat !== 2) $display("FAIL w16_add_latency got %0d exp 2", lat); else passed++;
        run16(OPC_SUB, 16'h1000, 16'h0001, 4'd0, r, f, lat);
        total++; if (r !== 16'h0FFF || f !== 8'h60) $display("FAIL w16_sub got %h/%h exp 0FFF/60", r, f); else passed++;
        run16(OPC_SWAP, 16'h12AB, 16'h0000, 4'd0, r, f, lat);
        total++; if (r !== 16'hAB12 || f !== 8'h00) $display("FAIL w16_swap got %h/%h exp AB12/00", r, f); else passed++;
        run16(OPC_BIT, 16'h8000, 16'h0000, 4'd15, r, f, lat);
        total++; if (r !== 16'h8000 || f !== 8'h20) $display("FAIL w16_bit15 got %h/%h exp 8000/20", r, f); else passed++;
        run16(OPC_SRA, 16'h8000, 16'h0000, 4'd15, r, f, lat);
        total++; if (r !== 16'hFFFF || f !== 8'h00) $display("FAIL w16_sra15 got %h/%h exp FFFF/00", r, f); else passed++;
        total++; if (lat !== 16) $display("FAIL w16_sra15_latency got %0d exp 16", lat); else passed++;
    endtask

    task automatic test_daa();
        logic [7:0] r, f;
        int lat, low;
`ifdef CPU_ALU_DAA_EN
        setf8(8'h00);
        run8(OPC_ADD, 8'h45, 8'h38, 3'd0, r, f, lat, low);
        total++; if (r !== 8'h7D || f !== 8'h00) $display("FAIL daa_pre_add got %h/%h exp 7D/00", r, f); else passed++;
        run8(OPC_DAA, 8'h7D, 8'h00, 3'd0, r, f, lat, low);
        total++; if (r !== 8'h83 || f !== 8'h00) $display("FAIL daa_low got %h/%h exp 83/00", r, f); else passed++;
        run8(OPC_ADD, 8'h99, 8'h01, 3'd0, r, f, lat, low);
        run8(OPC_DAA, 8'h9A, 8'h00, 3'd0, r, f, lat, low);
        total++; if (r !== 8'h00 || f !== 8'h90) $display("FAIL daa_high got %h/%h exp 00/90", r, f); else passed++;
`else
        setf8(8'h50);
        run8(OPC_DAA, 8'h7D, 8'h00, 3'd0, r, f, lat, low);
        total++; if (r !== 8'h7D || f !== 8'h50) $display("FAIL daa_disabled got %h/%h exp 7D/50", r, f); else passed++;
        total++; if (lat !== 2) $display("FAIL daa_disabled_latency got %0d exp 2", lat); else passed++;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        op_valid8 = 1'b0; op_code8 = '0; op_a8 = '0; op_b8 = '0; op_cnt8 = '0;
        flag_wr8 = 1'b0; flag_data8 = '0;
        op_valid16 = 1'b0; op_code16 = '0; op_a16 = '0; op_b16 = '0; op_cnt16 = '0;
        flag_wr16 = 1'b0; flag_data16 = '0;
        test_reset();
        test_exec_ops();
        test_shift_ops();
        test_back_to_back();
        test_flag_wr();
        test_width16();
        test_daa();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
